// File: rtl/rsp_pkg.sv
// Shared types and widths for the receiver-signal-path measurement blocks.
package rsp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int SAMPLE_W = 16;
  localparam int SQ_W     = 32;
  localparam int MAG_W    = 17;

  // Accumulator wide enough to sum a full window of squares without wrapping.
  function automatic int acc_w(input int win_log2);
    return SQ_W + win_log2;
  endfunction

endpackage

// File: rtl/rsp_sq_mag.sv
// Stage-1 register slice: squares and magnitude of one signed sample.
module rsp_sq_mag
  import rsp_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] x_i,
  input  logic                valid_i,
  output logic [SQ_W-1:0]     sq_o,
  output logic [MAG_W-1:0]    mag_o,
  output logic                valid_o
);

  logic signed [SAMPLE_W-1:0] x_s;
  logic signed [SQ_W-1:0]     prod;
  logic signed [MAG_W-1:0]    x_ext;

  logic [SQ_W-1:0]  sq_d,    sq_q;
  logic [MAG_W-1:0] mag_d,   mag_q;
  logic             valid_d, valid_q;

  always_comb begin
    x_s   = signed'(x_i);
    prod  = SQ_W'(x_s) * SQ_W'(x_s);
    // One extra bit so that |-32768| = 32768 is representable.
    x_ext = {x_i[SAMPLE_W-1], x_i};
    sq_d    = sq_q;
    mag_d   = mag_q;
    valid_d = valid_i;
    if (valid_i) begin
      sq_d  = unsigned'(prod);
      mag_d = x_ext[MAG_W-1] ? unsigned'(-x_ext) : unsigned'(x_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sq_q    <= '0;
      mag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sq_q    <= sq_d;
      mag_q   <= mag_d;
      valid_q <= valid_d;
    end
  end

  assign sq_o    = sq_q;
  assign mag_o   = mag_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/rsp_power_meter.sv
// Windowed mean-power / peak / overload meter with a valid/ready result port.
// Handshake: a result is transferred on any rising edge where meas_valid and meas_ready are both high;
// meas_valid and the result registers hold steady until then, and a new result may overwrite an unaccepted one.
module rsp_power_meter
  import rsp_pkg::*;
#(
  parameter int               WIN_LOG2   = 4,
  parameter logic [MAG_W-1:0] OVL_THRESH = 17'd32000,
  parameter int               OVL_MIN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [31:0]      meas_power,
  output logic [MAG_W-1:0] meas_peak,
  output logic             meas_ovl,
  output logic             overrun
);

  localparam int ACC_W = acc_w(WIN_LOG2);
  localparam int OVL_W = (OVL_MIN < 1) ? 1 : $clog2(OVL_MIN + 1);

  logic [SQ_W-1:0]  s1_sq;
  logic [MAG_W-1:0] s1_mag;
  logic             s1_valid;
  logic             unused_in_lo;

  assign unused_in_lo = ^in_data[15:0];

  rsp_sq_mag u_sq_mag (
    .clk     (clk),
    .reset   (reset),
    .x_i     (in_data[31:16]),
    .valid_i (enable && in_valid),
    .sq_o    (s1_sq),
    .mag_o   (s1_mag),
    .valid_o (s1_valid)
  );

  state_e              state_d, state_q;
  logic [WIN_LOG2-1:0] cnt_d, cnt_q;
  logic [ACC_W-1:0]    acc_d, acc_q, acc_next;
  logic [MAG_W-1:0]    peak_d, peak_q, peak_next;
  logic [OVL_W-1:0]    ovl_cnt_d, ovl_cnt_q, ovl_cnt_next;
  logic                win_done;

  logic                meas_valid_d, meas_valid_q;
  logic [31:0]         meas_power_d, meas_power_q;
  logic [MAG_W-1:0]    meas_peak_d, meas_peak_q;
  logic                meas_ovl_d, meas_ovl_q;
  logic                overrun_d, overrun_q;

  always_comb begin
    acc_next     = acc_q + ACC_W'(s1_sq);
    peak_next    = (s1_mag > peak_q) ? s1_mag : peak_q;
    ovl_cnt_next = ovl_cnt_q;
    if (s1_mag >= OVL_THRESH && ovl_cnt_q < OVL_W'(OVL_MIN)) begin
      ovl_cnt_next = ovl_cnt_q + OVL_W'(1);
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    peak_d    = peak_q;
    ovl_cnt_d = ovl_cnt_q;
    win_done  = 1'b0;

    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      acc_d     = '0;
      peak_d    = '0;
      ovl_cnt_d = '0;
    end else if (state_q == IDLE) begin
      state_d = RUN;
    end else if (s1_valid) begin
      if (cnt_q == '1) begin
        // Window closes here; the next window starts with the very next sample.
        win_done  = 1'b1;
        cnt_d     = '0;
        acc_d     = '0;
        peak_d    = '0;
        ovl_cnt_d = '0;
      end else begin
        cnt_d     = cnt_q + WIN_LOG2'(1);
        acc_d     = acc_next;
        peak_d    = peak_next;
        ovl_cnt_d = ovl_cnt_next;
      end
    end

    meas_valid_d = meas_valid_q && !meas_ready;
    meas_power_d = meas_power_q;
    meas_peak_d  = meas_peak_q;
    meas_ovl_d   = meas_ovl_q;
    overrun_d    = overrun_q;
    if (win_done) begin
      meas_valid_d = 1'b1;
      meas_power_d = acc_next[ACC_W-1:WIN_LOG2];
      meas_peak_d  = peak_next;
      meas_ovl_d   = (ovl_cnt_next >= OVL_W'(OVL_MIN));
      overrun_d    = overrun_q || (meas_valid_q && !meas_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      peak_q       <= '0;
      ovl_cnt_q    <= '0;
      meas_valid_q <= 1'b0;
      meas_power_q <= '0;
      meas_peak_q  <= '0;
      meas_ovl_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      peak_q       <= peak_d;
      ovl_cnt_q    <= ovl_cnt_d;
      meas_valid_q <= meas_valid_d;
      meas_power_q <= meas_power_d;
      meas_peak_q  <= meas_peak_d;
      meas_ovl_q   <= meas_ovl_d;
      overrun_q    <= overrun_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign meas_power = meas_power_q;
  assign meas_peak  = meas_peak_q;
  assign meas_ovl   = meas_ovl_q;
  assign overrun    = overrun_q;

endmodule
